// File: rtl/beat_sequencer.sv
// Beat sequencer: one-hot W1/W2/W3 timing generator for the hardwired controller.
// Sequences machine cycles of one, two or three beats, owns the console phase
// flag st0, the latched console mode and a machine-cycle counter.
module beat_sequencer #(
  parameter int unsigned CW          = 8,
  parameter bit          SINGLE_STEP = 1'b0
) (
  input  logic          i_t3,
  input  logic          i_clr,
  input  logic          i_qd,
  input  logic          i_swc,
  input  logic          i_swb,
  input  logic          i_swa,
  input  logic          i_short,
  input  logic          i_long,
  input  logic          i_stop,
  input  logic          i_set_st0,
  output logic          o_w1,
  output logic          o_w2,
  output logic          o_w3,
  output logic          o_st0,
  output logic          o_running,
  output logic [2:0]    o_mode,
  output logic          o_cyc_end,
  output logic [CW-1:0] o_icount
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StB1   = 2'd1,
    StB2   = 2'd2,
    StB3   = 2'd3
  } state_e;

  state_e        r_state;
  logic          r_w1;
  logic          r_w2;
  logic          r_w3;
  logic          r_running;
  logic          r_st0;
  logic [2:0]    r_mode;
  logic [CW-1:0] r_icount;

  logic [2:0]    w_sw;
  logic          w_mismatch;
  logic          w_end;
  logic          w_halt;

  // Decode whether the current beat is the last of its machine cycle.
  always_comb begin
    w_sw       = {i_swc, i_swb, i_swa};
    w_mismatch = (w_sw != r_mode);
    w_end      = 1'b0;
    unique case (r_state)
      StIdle:  w_end = 1'b0;
      StB1:    w_end = i_stop | w_mismatch | i_short;
      StB2:    w_end = i_stop | w_mismatch | ~i_long;
      StB3:    w_end = 1'b1;
      default: w_end = 1'b0;
    endcase
    // SINGLE_STEP only matters when a cycle is completing, which is the only
    // time w_halt is consulted.
    w_halt = i_stop | w_mismatch | SINGLE_STEP;
  end

  // Beat FSM with registered one-hot beat outputs, st0, mode and cycle counter.
  always_ff @(posedge i_t3) begin
    if (i_clr) begin
      r_state   <= StIdle;
      r_w1      <= 1'b0;
      r_w2      <= 1'b0;
      r_w3      <= 1'b0;
      r_running <= 1'b0;
      r_st0     <= 1'b0;
      r_mode    <= 3'b000;
      r_icount  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Console switches changed while stopped: re-latch and restart phase.
          if (w_mismatch) begin
            r_st0  <= 1'b0;
            r_mode <= w_sw;
          end
          if (i_qd) begin
            r_state   <= StB1;
            r_w1      <= 1'b1;
            r_w2      <= 1'b0;
            r_w3      <= 1'b0;
            r_running <= 1'b1;
            r_mode    <= w_sw;
          end
        end
        default: begin
          if (w_end) begin
            r_icount <= r_icount + CW'(1);
            // A mode change always restarts the console phase, even if the
            // decoder asked for st0 in the same beat.
            if (w_mismatch) begin
              r_st0 <= 1'b0;
            end else if (i_set_st0) begin
              r_st0 <= 1'b1;
            end
            if (w_halt) begin
              r_state   <= StIdle;
              r_w1      <= 1'b0;
              r_w2      <= 1'b0;
              r_w3      <= 1'b0;
              r_running <= 1'b0;
            end else begin
              r_state   <= StB1;
              r_w1      <= 1'b1;
              r_w2      <= 1'b0;
              r_w3      <= 1'b0;
              r_running <= 1'b1;
            end
          end else if (r_state == StB1) begin
            r_state <= StB2;
            r_w1    <= 1'b0;
            r_w2    <= 1'b1;
            r_w3    <= 1'b0;
          end else begin
            r_state <= StB3;
            r_w1    <= 1'b0;
            r_w2    <= 1'b0;
            r_w3    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_w1      = r_w1;
  assign o_w2      = r_w2;
  assign o_w3      = r_w3;
  assign o_running = r_running;
  assign o_st0     = r_st0;
  assign o_mode    = r_mode;
  assign o_icount  = r_icount;
  assign o_cyc_end = w_end;

endmodule
